// File: rtl/mux_pkg.sv
// Shared definitions for the 2:1 vector mux upstream controller.
package mux_pkg;

  localparam int unsigned MUX_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/chan_hold.sv
// One-entry valid/ready holding register; a drain in the same cycle frees the slot for a refill.
module chan_hold #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  input  logic             drain_i,
  output logic             ready_o,
  output logic             full_o,
  output logic             full_nxt_o,
  output logic [WIDTH-1:0] data_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load;

  assign ready_o = !rst_i && (!full_q || drain_i);
  assign load    = valid_i && ready_o;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o     = full_q;
  assign full_nxt_o = full_d;
  assign data_o     = data_q;

endmodule

// File: rtl/mux_chan_ctrl.sv
// Two-channel buffer and burst-bounded arbiter driving the 2:1 vector mux and qualifying its output.
module mux_chan_ctrl
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = MUX_W,
  parameter int unsigned BURST = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_data_i,
  input  logic             a_valid_i,
  output logic             a_ready_o,
  input  logic [WIDTH-1:0] b_data_i,
  input  logic             b_valid_i,
  output logic             b_ready_o,
  output logic [WIDTH-1:0] a_vec_o,
  output logic [WIDTH-1:0] b_vec_o,
  output logic             sel_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] outvec_o
);

  localparam int unsigned      CNT_W    = $clog2(BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_b_q, last_b_d;
  logic             sel_q, sel_d;
  logic             a_full, b_full, a_nxt, b_nxt;
  logic             xfer, drain_a, drain_b;

  assign out_valid_o = ((state_q == SERVE_A) && a_full) || ((state_q == SERVE_B) && b_full);
  assign xfer        = out_valid_o && out_ready_i;
  assign drain_a     = xfer && (state_q == SERVE_A);
  assign drain_b     = xfer && (state_q == SERVE_B);

  chan_hold #(.WIDTH(WIDTH)) u_hold_a (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(a_data_i), .valid_i(a_valid_i), .drain_i(drain_a),
    .ready_o(a_ready_o), .full_o(a_full), .full_nxt_o(a_nxt), .data_o(a_vec_o)
  );

  chan_hold #(.WIDTH(WIDTH)) u_hold_b (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(b_data_i), .valid_i(b_valid_i), .drain_i(drain_b),
    .ready_o(b_ready_o), .full_o(b_full), .full_nxt_o(b_nxt), .data_o(b_vec_o)
  );

  // Decisions look at post-load occupancy so an accepted word is served on the very next cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_b_d = last_b_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (a_nxt && b_nxt) state_d = last_b_q ? SERVE_A : SERVE_B;
        else if (a_nxt)     state_d = SERVE_A;
        else if (b_nxt)     state_d = SERVE_B;
      end
      SERVE_A: begin
        if (xfer) begin
          last_b_d = 1'b0;
          cnt_d    = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);
          if (b_nxt && ((cnt_q == CNT_LAST) || !a_nxt)) begin
            state_d = SERVE_B;
            cnt_d   = '0;
          end
        end else if (!a_full) begin
          if (b_nxt) begin
            state_d = SERVE_B;
            cnt_d   = '0;
          end else if (!a_nxt) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      SERVE_B: begin
        if (xfer) begin
          last_b_d = 1'b1;
          cnt_d    = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);
          if (a_nxt && ((cnt_q == CNT_LAST) || !b_nxt)) begin
            state_d = SERVE_A;
            cnt_d   = '0;
          end
        end else if (!b_full) begin
          if (a_nxt) begin
            state_d = SERVE_A;
            cnt_d   = '0;
          end else if (!b_nxt) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    sel_d = (state_d == SERVE_B) ? SEL_B : SEL_A;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_b_q <= 1'b1;
      sel_q    <= SEL_A;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
      sel_q    <= sel_d;
    end
  end

  assign sel_o    = sel_q;
  assign outvec_o = sel_q ? b_vec_o : a_vec_o;

endmodule
